// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for an RV32I subset sharing one ALU and one memory port.
// The state and the sticky flags are registered; the strobes are decoded combinationally so they are valid in the same cycle.
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        EQ,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUctrl,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        ByteAddr,
    output logic        instr_done,
    output logic        illegal,
    output logic        mem_fault,
    output logic [3:0]  state
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic        TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR1    = 4'd11,
        JALR2    = 4'd12,
        LUI      = 4'd13,
        TRAP     = 4'd15
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               set_ill, set_flt, wait_st, timeout_hit;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign state        = state_q;

    // Next state, control word and stall counter
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUctrl     = ALU_ADD;
        ResultSrc   = 2'b00;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        ByteAddr    = 1'b0;
        instr_done  = 1'b0;
        set_ill     = 1'b0;
        set_flt     = 1'b0;
        wait_st     = 1'b0;
        cnt_d       = '0;
        timeout_hit = TO_EN && (cnt_q == CNT_W'(LIMIT));

        case (opcode)
            OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:                   ImmSrc = 3'b001;
            OP_BR:                      ImmSrc = 3'b010;
            OP_JAL:                     ImmSrc = 3'b011;
            OP_LUI:                     ImmSrc = 3'b100;
            default:                    ImmSrc = 3'b000;
        endcase

        case (state_q)
            FETCH: begin
                wait_st   = 1'b1;
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                    set_flt = 1'b1;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR1;
                    OP_LUI:            state_d = LUI;
                    default: begin
                        state_d = TRAP;
                        set_ill = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                wait_st  = 1'b1;
                MemRead  = 1'b1;
                AdrSrc   = 1'b1;
                ByteAddr = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                    set_flt = 1'b1;
                end
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                wait_st  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                ByteAddr = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                    set_flt = 1'b1;
                end
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                case (funct3)
                    3'b000:  ALUctrl = instr[30] ? ALU_SUB : ALU_ADD;
                    3'b100:  ALUctrl = ALU_XOR;
                    3'b111:  ALUctrl = ALU_AND;
                    default: ALUctrl = ALU_ADD;
                endcase
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUctrl    = ALU_SUB;
                PCWrite    = ((funct3 == 3'b000) && EQ) || ((funct3 == 3'b001) && !EQ);
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = JALR2;
            end
            JALR2: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            LUI: begin
                ResultSrc  = 2'b11;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = FETCH;
        endcase

        // Stall cycles accumulate only while parked in a handshake state
        if (TO_EN && wait_st && !mem_ready && (state_d == state_q))
            cnt_d = cnt_q + CNT_W'(1);

        if (rst) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            MemRead    = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            illegal   <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (set_ill) illegal   <= 1'b1;
            if (set_flt) mem_fault <= 1'b1;
        end
    end

endmodule
